// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: radix-2 restoring mantissa division, one quotient bit per clock.
// Optional round-to-nearest-even when FP_DIV_ROUND_EN is defined; truncation otherwise.
module fp_div_seq #(
  parameter  int EXP_WIDTH  = 8,
  parameter  int MANT_WIDTH = 23,
  localparam int DATA_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_start,
  input  logic [DATA_WIDTH-1:0] in_numA,
  input  logic [DATA_WIDTH-1:0] in_numB,
  output logic                  out_busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_div_by_zero,
  output logic                  out_invalid,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  localparam int Q   = MANT_WIDTH + 3;
  localparam int EXW = EXP_WIDTH + 2;
  localparam int CW  = $clog2(Q + 1);

  localparam logic signed [EXW-1:0] BIAS     = EXW'((1 << (EXP_WIDTH - 1)) - 1);
  localparam logic signed [EXW-1:0] EXP_MAX  = EXW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EXW-1:0] EXP_ONE  = EXW'(1);
  localparam logic signed [EXW-1:0] EXP_ZERO = EXW'(0);
  localparam logic [CW-1:0]         CNT_LOAD = CW'(Q - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]         CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_DIV    = 2'd2,
    ST_NORM   = 2'd3
  } state_t;

  state_t state_r, state_s;
  logic   busy_s;

  logic [DATA_WIDTH-1:0]   a_r, b_r;
  logic                    sign_r;
  logic signed [EXW-1:0]   exp_r;
  logic [MANT_WIDTH+1:0]   rem_r;
  logic [MANT_WIDTH:0]     div_r;
  logic [Q-1:0]            q_r;
  logic [CW-1:0]           cnt_r;
  logic                    spec_r, spec_dbz_r, spec_inv_r;
  logic [DATA_WIDTH-1:0]   spec_res_r;

  // Operand field decode (inputs to the UNPACK step)
  logic [EXP_WIDTH-1:0]    a_exp_s, b_exp_s;
  logic [MANT_WIDTH-1:0]   a_frac_s, b_frac_s;
  logic                    sign_s;
  logic                    a_zero_s, b_zero_s, a_inf_s, b_inf_s, a_nan_s, b_nan_s;
  logic [MANT_WIDTH:0]     mant_a_s, mant_b_s;
  logic signed [EXW-1:0]   e_unp_s;

  assign a_exp_s  = a_r[DATA_WIDTH-2 -: EXP_WIDTH];
  assign b_exp_s  = b_r[DATA_WIDTH-2 -: EXP_WIDTH];
  assign a_frac_s = a_r[MANT_WIDTH-1:0];
  assign b_frac_s = b_r[MANT_WIDTH-1:0];
  assign sign_s   = a_r[DATA_WIDTH-1] ^ b_r[DATA_WIDTH-1];

  // Subnormals have exp == 0 and are flushed to zero, so the hidden bit is simply |exp.
  assign a_zero_s = ~(|a_exp_s);
  assign b_zero_s = ~(|b_exp_s);
  assign a_inf_s  = (&a_exp_s) & ~(|a_frac_s);
  assign b_inf_s  = (&b_exp_s) & ~(|b_frac_s);
  assign a_nan_s  = (&a_exp_s) & (|a_frac_s);
  assign b_nan_s  = (&b_exp_s) & (|b_frac_s);
  assign mant_a_s = {~a_zero_s, a_frac_s};
  assign mant_b_s = {~b_zero_s, b_frac_s};
  assign e_unp_s  = $signed({2'b00, a_exp_s}) - $signed({2'b00, b_exp_s}) + BIAS;

  logic                  spec_s, spec_dbz_s, spec_inv_s;
  logic [DATA_WIDTH-1:0] spec_res_s;

  // Special-operand classification in priority order
  always_comb begin
    spec_s     = 1'b0;
    spec_dbz_s = 1'b0;
    spec_inv_s = 1'b0;
    spec_res_s = {DATA_WIDTH{1'b0}};
    if (a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s)) begin
      spec_s     = 1'b1;
      spec_inv_s = 1'b1;
      spec_res_s = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    end else if (a_inf_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (b_zero_s) begin
      spec_s     = 1'b1;
      spec_dbz_s = 1'b1;
      spec_res_s = {sign_s, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
    end else if (a_zero_s | b_inf_s) begin
      spec_s     = 1'b1;
      spec_res_s = {sign_s, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      spec_s     = 1'b0;
    end
  end

  logic                  rem_ge_s;
  logic [MANT_WIDTH+1:0] rem_sub_s, rem_next_s;

  // One restoring-division step; the remainder stays below twice the divisor, so no bit is lost
  always_comb begin
    rem_ge_s = (rem_r >= {1'b0, div_r});
    if (rem_ge_s) begin
      rem_sub_s = rem_r - {1'b0, div_r};
    end else begin
      rem_sub_s = rem_r;
    end
    rem_next_s = rem_sub_s << 1;
  end

  logic [Q-2:0]          qn_s;
  logic signed [EXW-1:0] e_n_s, e_fin_s;
  logic                  guard_s, sticky_s, round_up_s;
  logic [MANT_WIDTH:0]   frac_ext_s;

  // Normalisation: quotient lies in (0.5, 2), so at most one left shift is needed
  always_comb begin
    if (q_r[Q-1]) begin
      qn_s  = q_r[Q-2:0];
      e_n_s = exp_r;
    end else begin
      qn_s  = {q_r[Q-3:0], 1'b0};
      e_n_s = exp_r - EXP_ONE;
    end
  end

  // Bit 0 of the normalised quotient lies below the guard, so it belongs to the sticky bit.
  assign guard_s  = qn_s[1];
  assign sticky_s = qn_s[0] | (|rem_r);

`ifdef FP_DIV_ROUND_EN
  assign round_up_s = guard_s & (sticky_s | qn_s[2]);
`else
  logic trunc_unused_s;
  assign round_up_s     = 1'b0;
  assign trunc_unused_s = guard_s ^ sticky_s;
`endif

  assign frac_ext_s = {1'b0, qn_s[Q-2:2]} + {{MANT_WIDTH{1'b0}}, round_up_s};
  assign e_fin_s    = frac_ext_s[MANT_WIDTH] ? (e_n_s + EXP_ONE) : e_n_s;

  logic [DATA_WIDTH-1:0] norm_res_s;
  logic                  norm_ovf_s, norm_unf_s;

  // Final result selection: specials, then exponent range, then the normal packed value
  always_comb begin
    norm_res_s = {DATA_WIDTH{1'b0}};
    norm_ovf_s = 1'b0;
    norm_unf_s = 1'b0;
    if (spec_r) begin
      norm_res_s = spec_res_r;
    end else if (e_fin_s >= EXP_MAX) begin
      norm_res_s = {sign_r, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
      norm_ovf_s = 1'b1;
    end else if (e_fin_s <= EXP_ZERO) begin
      norm_res_s = {sign_r, {(DATA_WIDTH-1){1'b0}}};
      norm_unf_s = 1'b1;
    end else begin
      norm_res_s = {sign_r, e_fin_s[EXP_WIDTH-1:0], frac_ext_s[MANT_WIDTH-1:0]};
    end
  end

  // FSM next-state and busy decode
  always_comb begin
    state_s = state_r;
    busy_s  = 1'b1;
    case (state_r)
      ST_IDLE: begin
        busy_s = in_start;
        if (in_start) begin
          state_s = ST_UNPACK;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_UNPACK: state_s = ST_DIV;
      ST_DIV: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_NORM;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_NORM: state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, unpack and iterative division datapath
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      a_r        <= {DATA_WIDTH{1'b0}};
      b_r        <= {DATA_WIDTH{1'b0}};
      sign_r     <= 1'b0;
      exp_r      <= EXP_ZERO;
      rem_r      <= {(MANT_WIDTH+2){1'b0}};
      div_r      <= {(MANT_WIDTH+1){1'b0}};
      q_r        <= {Q{1'b0}};
      cnt_r      <= CNT_ZERO;
      spec_r     <= 1'b0;
      spec_dbz_r <= 1'b0;
      spec_inv_r <= 1'b0;
      spec_res_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_start) begin
            a_r <= in_numA;
            b_r <= in_numB;
          end
        end
        ST_UNPACK: begin
          sign_r     <= sign_s;
          exp_r      <= e_unp_s;
          rem_r      <= {1'b0, mant_a_s};
          div_r      <= mant_b_s;
          q_r        <= {Q{1'b0}};
          cnt_r      <= CNT_LOAD;
          spec_r     <= spec_s;
          spec_dbz_r <= spec_dbz_s;
          spec_inv_r <= spec_inv_s;
          spec_res_r <= spec_res_s;
        end
        ST_DIV: begin
          rem_r <= rem_next_s;
          q_r   <= {q_r[Q-2:0], rem_ge_s};
          cnt_r <= cnt_r - CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs: result/flags load in NORM, flags clear on the next accept
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_busy        <= 1'b0;
      out_valid       <= 1'b0;
      out_result      <= {DATA_WIDTH{1'b0}};
      out_div_by_zero <= 1'b0;
      out_invalid     <= 1'b0;
      out_overflow    <= 1'b0;
      out_underflow   <= 1'b0;
    end else begin
      out_busy <= busy_s;
      if (state_r == ST_NORM) begin
        out_valid       <= 1'b1;
        out_result      <= norm_res_s;
        out_div_by_zero <= spec_r & spec_dbz_r;
        out_invalid     <= spec_r & spec_inv_r;
        out_overflow    <= norm_ovf_s;
        out_underflow   <= norm_unf_s;
      end else begin
        out_valid <= 1'b0;
        if ((state_r == ST_IDLE) && in_start) begin
          out_div_by_zero <= 1'b0;
          out_invalid     <= 1'b0;
          out_overflow    <= 1'b0;
          out_underflow   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed testbench for fp_div_seq (binary32): results, flags, latency, handshake and async reset.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] num_a, num_b;
  logic        busy, valid, dbz, inv, ovf, unf;
  logic [31:0] result;
  logic [3:0]  flags;

  assign flags = {dbz, inv, ovf, unf};

  fp_div_seq dut (
    .in_clk          (clk),
    .in_rst          (rst),
    .in_start        (start),
    .in_numA         (num_a),
    .in_numB         (num_b),
    .out_busy        (busy),
    .out_valid       (valid),
    .out_result      (result),
    .out_div_by_zero (dbz),
    .out_invalid     (inv),
    .out_overflow    (ovf),
    .out_underflow   (unf)
  );

  always #5 clk = ~clk;

`ifdef FP_DIV_ROUND_EN
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] ONE_THIRD = 32'h3EAAAAAA;
`endif

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for out_valid; lat = -1 if it never comes.
  task automatic run_op(input logic [31:0] na, input logic [31:0] nb,
                        output logic [31:0] res, output logic [3:0] fl, output int lat,
                        output logic [31:0] early_res, output logic [3:0] early_fl);
    @(negedge clk);
    num_a = na;
    num_b = nb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    res = 32'h0;
    fl = 4'h0;
    early_res = 32'h0;
    early_fl = 4'h0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 0) begin
        early_res = result;
        early_fl  = flags;
      end
      if (valid) begin
        lat = n;
        res = result;
        fl  = flags;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;   // {div_by_zero, invalid, overflow, underflow}
  } vec_t;

  vec_t vecs[13];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, early_res, prev_res, hs_res;
    logic [3:0]  fl, early_fl, hs_fl;
    int          lat, vcnt, bcnt;
    logic        btb_busy;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h40400000, ONE_THIRD,    4'b0000};
    vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b1000};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0100};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0100};
    vecs[5]  = '{32'h00000000, 32'h40000000, 32'h00000000, 4'b0000};
    vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010};
    vecs[7]  = '{32'h00800000, 32'h4B000000, 32'h00000000, 4'b0001};
    vecs[8]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0100};
    vecs[10] = '{32'h40400000, 32'hFF800000, 32'h80000000, 4'b0000};
    vecs[11] = '{32'h3F800000, 32'h3F000000, 32'h40000000, 4'b0000};
    vecs[12] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000};

    rst   = 1'b1;
    start = 1'b0;
    num_a = 32'h0;
    num_b = 32'h0;
    repeat (3) @(negedge clk);
    check_val("rst_result", result, 32'h0);
    check_val("rst_flags", 32'(flags), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_valid", 32'(valid), 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed vectors: result, flags, fixed latency, held result and flag clear on accept
    prev_res = 32'h0;
    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, fl, lat, early_res, early_fl);
      check_val($sformatf("v%0d_result", i), res, vecs[i].q);
      check_val($sformatf("v%0d_flags", i), 32'(fl), 32'(vecs[i].f));
      check_val($sformatf("v%0d_latency", i), lat, 32'd28);
      check_val($sformatf("v%0d_flags_cleared", i), 32'(early_fl), 32'h0);
      check_val($sformatf("v%0d_result_held", i), early_res, prev_res);
      prev_res = vecs[i].q;
    end
    @(negedge clk);
    check_val("idle_busy", 32'(busy), 32'h0);
    check_val("idle_valid", 32'(valid), 32'h0);

    // Handshake: second start at edge 5 is ignored, back-to-back start at edge 29 accepted
    @(negedge clk);
    num_a = 32'h40C00000;
    num_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    vcnt = 0;
    bcnt = 0;
    hs_res = 32'h0;
    hs_fl = 4'h0;
    for (int k = 0; k <= 28; k++) begin
      @(negedge clk);
      if (k >= 1 && busy) bcnt++;
      if (valid) begin
        vcnt++;
        hs_res = result;
        hs_fl  = flags;
      end
      if (k == 4) begin
        num_a = 32'h00000000;
        num_b = 32'h00000000;
        start = 1'b1;
      end else if (k == 5) begin
        start = 1'b0;
      end
      if (k == 28) begin
        num_a = 32'h3F800000;
        num_b = 32'h3F000000;
        start = 1'b1;
      end
    end
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    res = 32'h0;
    btb_busy = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (n == 0) btb_busy = busy;
      if (valid) begin
        lat = n;
        res = result;
        break;
      end
    end
    check_val("hs_valid_count", vcnt, 32'd1);
    check_val("hs_busy_cycles", bcnt, 32'd28);
    check_val("hs_result", hs_res, 32'h40400000);
    check_val("hs_flags", 32'(hs_fl), 32'h0);
    check_val("btb_busy", 32'(btb_busy), 32'h1);
    check_val("btb_latency", lat, 32'd28);
    check_val("btb_result", res, 32'h40000000);

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    num_a = 32'h40C00000;
    num_b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    check_val("mid_busy", 32'(busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_result", result, 32'h0);
    check_val("arst_busy", 32'(busy), 32'h0);
    check_val("arst_flags", 32'(flags), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check_val("arst_no_valid", vcnt, 32'd0);
    run_op(32'h3F800000, 32'h3F800000, res, fl, lat, early_res, early_fl);
    check_val("post_rst_result", res, 32'h3F800000);
    check_val("post_rst_flags", 32'(fl), 32'h0);
    check_val("post_rst_latency", lat, 32'd28);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
